// File: rtl/ram_bank_pkg.sv
// Shared definitions for the ram_bank storage block: clear-sequencer state
// encoding and the depth helper used to size the array.
package ram_bank_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int unsigned depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_bank_if.sv
// Bus-side signal bundle of ram_bank: addressed write/read controls, the
// display read port and the status flags.
interface ram_bank_if #(
    parameter int p_data_width = 7,
    parameter int p_addr_width = 3
);
    logic [p_addr_width-1:0] i_w_addr;
    logic [p_data_width-1:0] i_w_in;
    logic                    i_w_we;
    logic                    i_w_oe;
    logic                    i_w_clr;
    logic [p_addr_width-1:0] i_w_disp_addr;
    logic [p_data_width-1:0] o_w_disp_out;
    logic                    o_w_valid;
    logic                    o_w_busy;

    modport master (
        output i_w_addr, i_w_in, i_w_we, i_w_oe, i_w_clr, i_w_disp_addr,
        input  o_w_disp_out, o_w_valid, o_w_busy
    );

    modport slave (
        input  i_w_addr, i_w_in, i_w_we, i_w_oe, i_w_clr, i_w_disp_addr,
        output o_w_disp_out, o_w_valid, o_w_busy
    );
endinterface

// File: rtl/ram_bank_clr_seq.sv
// Clear sequencer: after reset or a clear request it walks every address once,
// issuing a zero-write per cycle, and reports busy while doing so.
module ram_bank_clr_seq
    import ram_bank_pkg::*;
#(
    parameter int p_addr_width = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    output logic                    busy,
    output logic                    clr_we,
    output logic [p_addr_width-1:0] clr_addr
);

    // The last address of the array is always all-ones.
    localparam logic [p_addr_width-1:0] LAST_ADDR = '1;

    state_t                  state_q;
    state_t                  state_d;
    logic [p_addr_width-1:0] cnt_q;
    logic [p_addr_width-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_addr = cnt_q;
    assign busy     = (state_q == ST_CLEAR);

endmodule

// File: rtl/ram_bank.sv
// Multi-word storage bank on the shared data bus: addressed write, registered
// tri-state read, asynchronous display read and a sequenced clear sweep.
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int p_data_width = 7,
    parameter int p_addr_width = 3
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    ram_bank_if.slave               bus,
    output logic [p_data_width-1:0] o_w_out
);

    localparam int unsigned DEPTH = depth(p_addr_width);

    logic [p_data_width-1:0] mem [DEPTH];
    logic [p_data_width-1:0] rd_q;
    logic                    valid_q;
    logic                    busy;
    logic                    clr_we;
    logic [p_addr_width-1:0] clr_addr;
    logic                    bus_wr;
    logic                    bus_rd;

    ram_bank_clr_seq #(
        .p_addr_width(p_addr_width)
    ) u_clr_seq (
        .clk     (i_w_clk),
        .rst_n   (i_w_reset),
        .clr     (bus.i_w_clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // A clear request in IDLE wins over a same-cycle write or read.
    assign bus_wr = !busy && !bus.i_w_clr && bus.i_w_we && !bus.i_w_oe;
    assign bus_rd = !busy && !bus.i_w_clr && bus.i_w_oe && !bus.i_w_we;

    always_ff @(posedge i_w_clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (bus_wr) begin
            mem[bus.i_w_addr] <= bus.i_w_in;
        end
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus_rd;
            if (bus_rd) begin
                rd_q <= mem[bus.i_w_addr];
            end
        end
    end

    assign o_w_out          = valid_q ? rd_q : {p_data_width{1'bz}};
    assign bus.o_w_valid    = valid_q;
    assign bus.o_w_busy     = busy;
    assign bus.o_w_disp_out = mem[bus.i_w_disp_addr];

endmodule

// File: tb/tb_ram_bank.sv
// Randomised and directed bench for ram_bank with a queue scoreboard and an
// array-based reference model of the bank contents and clear sweep.
module tb_ram_bank;

    localparam int W = 7;
    localparam int A = 3;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    wire  [W-1:0] out_bus;

    ram_bank_if #(.p_data_width(W), .p_addr_width(A)) bus_if ();

    ram_bank #(
        .p_data_width(W),
        .p_addr_width(A)
    ) dut (
        .i_w_clk  (clk),
        .i_w_reset(rst_n),
        .bus      (bus_if),
        .o_w_out  (out_bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mref [D];
    bit           known [D];
    int           sweep_left = D;
    logic [W-1:0] exp_q [$];
    int           checks = 0;
    int           errors = 0;
    bit           last_busy;
    bit           last_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at negedge, check status/display, then advance the model at posedge.
    task automatic step(input bit r, input bit c, input bit w, input bit o,
                        input logic [A-1:0] a, input logic [W-1:0] d, input logic [A-1:0] da);
        @(negedge clk);
        rst_n                = r;
        bus_if.i_w_clr       = c;
        bus_if.i_w_we        = w;
        bus_if.i_w_oe        = o;
        bus_if.i_w_addr      = a;
        bus_if.i_w_in        = d;
        bus_if.i_w_disp_addr = da;
        if (!r) sweep_left = D;
        #1;
        last_busy  = bus_if.o_w_busy;
        last_valid = bus_if.o_w_valid;
        chk("busy", {31'd0, bus_if.o_w_busy}, {31'd0, (sweep_left > 0)});
        if (known[da]) chk("disp", {25'd0, bus_if.o_w_disp_out}, {25'd0, mref[da]});
        @(posedge clk);
        if (r) begin
            if (sweep_left > 0) begin
                mref[D - sweep_left]  = '0;
                known[D - sweep_left] = 1'b1;
                sweep_left--;
            end else if (c) begin
                sweep_left = D;
            end else if (w && !o) begin
                mref[a]  = d;
                known[a] = 1'b1;
            end else if (o && !w) begin
                exp_q.push_back(mref[a]);
            end
        end
    endtask

    task automatic nop(input logic [A-1:0] da);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, da);
    endtask

    task automatic drain();
        nop(0);
        nop(0);
        chk("q_drain", exp_q.size(), 0);
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            nop(3'(i));
            if (last_busy) n++;
        end
        chk(name, n, D);
    endtask

    // Scoreboard monitor: every driven bus word must match the oldest expected read.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus_if.o_w_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got %0h expected no read at %0t", out_bus, $time);
                end else begin
                    chk("rd_data", {25'd0, out_bus}, {25'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.i_w_clr       = 1'b0;
        bus_if.i_w_we        = 1'b0;
        bus_if.i_w_oe        = 1'b0;
        bus_if.i_w_addr      = '0;
        bus_if.i_w_in        = '0;
        bus_if.i_w_disp_addr = '0;
        for (int i = 0; i < D; i++) known[i] = 1'b0;
        #1 rst_n = 1'b0;

        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b1, '0, '0, '0);
        chk("reset_valid", {31'd0, last_valid}, 0);
        count_busy("init_sweep_len");
        for (int i = 0; i < D; i++) begin
            nop(3'(i));
            chk("init_zero", {25'd0, bus_if.o_w_disp_out}, 0);
        end

        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 7'h2A, 3'd3);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 7'h55, 3'd7);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, '0, 3'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd7, '0, 3'd7);
        chk("rd3_valid", {31'd0, last_valid}, 1);
        nop(3'd7);
        chk("rd7_valid", {31'd0, last_valid}, 1);
        nop(3'd7);
        chk("oe_low_valid", {31'd0, last_valid}, 0);
        drain();

        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 7'h11, 3'd3);
        nop(3'd3);
        chk("we_oe_nowrite", {25'd0, bus_if.o_w_disp_out}, 32'h2A);
        chk("we_oe_valid", {31'd0, last_valid}, 0);

        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 7'h7F, 3'd5);
        count_busy("clr_sweep_len");
        nop(3'd5);
        chk("clr_mem5", {25'd0, bus_if.o_w_disp_out}, 0);
        nop(3'd3);
        chk("clr_mem3", {25'd0, bus_if.o_w_disp_out}, 0);

        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 7'h33, 3'd6);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 3'd6);
        for (int i = 0; i < 4; i++) nop(3'd6);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'd6);
        count_busy("restart_sweep_len");
        for (int i = 0; i < D; i++) begin
            nop(3'(i));
            chk("restart_zero", {25'd0, bus_if.o_w_disp_out}, 0);
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 3'(i), 7'(i + 1), 3'(i));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 3'(i), '0, 3'(i));
            if (i > 0) chk("stream_valid", {31'd0, last_valid}, 1);
        end
        nop(0);
        chk("stream_valid_last", {31'd0, last_valid}, 1);
        drain();

        for (int i = 0; i < 400; i++) begin
            step(1'b1, ($urandom_range(39) == 0), 1'($urandom), 1'($urandom),
                 3'($urandom), 7'($urandom), 3'($urandom));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bank.md
Name: ram_bank

Overview:
Parametrised multi-word successor to the single-register bus cell. A 2**p_addr_width x p_data_width storage bank with an addressed write, a registered read onto a shared tri-state bus, and a second asynchronous display read port. Contains a clear sequencer that zeroes every word after reset or on request. Sits on the lab's shared data bus, alongside display/7-segment logic.

Parameters:
- p_data_width, 7, width of each word and of the data bus.
- p_addr_width, 3, address width. Depth D = 2**p_addr_width.

Ports:
- i_w_clk  in  1  single clock; all state updates on posedge.
- i_w_reset  in  1  asynchronous, active-low reset.
- i_w_addr  in  p_addr_width  word address for bus write/read.
- i_w_in  in  p_data_width  write data.
- i_w_we  in  1  write enable.
- i_w_oe  in  1  output (read) enable.
- i_w_clr  in  1  start clear sweep (level-sampled in IDLE).
- i_w_disp_addr  in  p_addr_width  display port address.
- o_w_out  out  p_data_width  tri-state bus output; high-Z when not driving.
- o_w_disp_out  out  p_data_width  combinational mem[i_w_disp_addr].
- o_w_valid  out  1  high while o_w_out is driven.
- o_w_busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (i_w_reset==0, async): state=CLEAR, sweep counter=0, read register=0, o_w_valid=0, o_w_busy=1, o_w_out=Z. Array is not async-reset. Zeroing is done by the sweep.
- Reset deasserted mid-sweep or asserted again mid-sweep: the sweep restarts at address 0.
- CLEAR state, one word per cycle:
  - Write mem[cnt]<=0, then cnt<=cnt+1.
  - When cnt==D-1, go to IDLE. cnt wraps to 0.
  - Sweep length is exactly D cycles. o_w_busy falls on the edge that enters IDLE.
  - i_w_we, i_w_oe and i_w_clr are ignored. o_w_valid=0 and o_w_out=Z throughout.
- IDLE state, per cycle. Priority is clear > write > read:
  - i_w_clr==1: go to CLEAR, cnt=0. A we/oe in the same cycle is dropped. o_w_valid<=0.
  - we==1 && oe==0: mem[i_w_addr]<=i_w_in. o_w_valid<=0.
  - oe==1 && we==0: read register<=mem[i_w_addr], o_w_valid<=1. Latency is 1 cycle; data appears after the edge following the request.
  - we==oe (both 0 or both 1): no operation. o_w_valid<=0. The read register holds its value.
- o_w_out = o_w_valid ? read register : all-Z. Continuous oe streams one word per cycle.
- Write then read of the same address on the next cycle returns the new data. There is no bypass requirement, because we and oe are mutually exclusive.
- o_w_disp_out is an asynchronous read. It reflects writes and sweep zeroing immediately after the edge. Contents are X before the first sweep completes.
- Widths: the counter is p_addr_width bits. Addresses need no range check, since all codes are valid.

Decomposition:
- Shared package ram_bank_pkg holds:
  - state encoding constants ST_IDLE and ST_CLEAR, a 1-bit state;
  - a depth helper constant, D = 1 << p_addr_width.
- One sub-module is natural: ram_bank_clr_seq. It holds the FSM, the sweep counter, busy, and the clear write-enable/address outputs.
- The top module holds the array, the write mux (sweep vs bus), the read register and the tri-state driver.

Test Plan (W=7, A=3, D=8):
- Reset then release: o_w_busy=1 for exactly 8 cycles, then 0. Every o_w_disp_out over addresses 0..7 reads 7'h00. o_w_out=Z throughout.
- Write 7'h2A@3 and 7'h55@7, then oe on addr 3: the next cycle gives o_w_out=7'h2A with valid=1. Addr 7 then gives 7'h55. With oe=0, o_w_out=Z.
- we=oe=1 with addr 3 and in 7'h11: no write (disp@3 stays 7'h2A), valid=0, o_w_out=Z.
- i_w_clr=1 together with we to addr 5 and data 7'h7F: busy rises. After 8 cycles mem[5]=0 and mem[3]=0. The write is dropped.
- Reset pulsed at sweep cycle 4: the sweep restarts, busy stays high for 8 full cycles after release, and all words end at 0.
- Streaming oe over addresses 0,1,2 after writing 1,2,3: o_w_out gives 1,2,3 on consecutive cycles with valid continuously high.
